// File: rtl/receive.sv
// Receive buffer: accepts instruction words from a transmitter into a small RAM and flags done/overflow.
// Optional idle watchdog in RECV is enabled by defining RECEIVE_TIMEOUT_EN.
module receive #(
    parameter int IWIDTH  = 32,
    parameter int DEPTH   = 2,
    parameter int AWIDTH  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_i_start,
    input  logic [IWIDTH-1:0] r_i_instr,
    input  logic              r_i_last,
    input  logic              r_i_ack,
    output logic              r_o_syn,
    input  logic [AWIDTH-1:0] r_i_rd_addr,
    output logic [IWIDTH-1:0] r_o_rd_data,
    output logic [AWIDTH:0]   r_o_count,
    output logic              r_o_done,
    output logic              r_o_err
);

    typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} state_e;

    localparam logic [AWIDTH:0] DEPTH_C = DEPTH[AWIDTH:0];
    localparam logic [AWIDTH:0] ONE_C   = 1;

    state_e              state_q, state_d;
    logic [AWIDTH:0]     count_q, count_d;
    logic                wr_en;
    logic [IWIDTH-1:0]   mem [DEPTH];
    logic [IWIDTH-1:0]   rd_data_q;

`ifdef RECEIVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_C   = TIMEOUT[TW-1:0];
    localparam logic [TW-1:0] TONE_C = 1;
    logic [TW-1:0] idle_q, idle_d;
`else
    // Watchdog not built; the empty block only keeps TIMEOUT referenced.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
`ifdef RECEIVE_TIMEOUT_EN
        idle_d  = '0;
`endif
        case (state_q)
            RECV: begin
                if (r_i_ack) begin
                    if (count_q < DEPTH_C) begin
                        wr_en   = 1'b1;
                        count_d = count_q + ONE_C;
                        if (r_i_last) state_d = DONE;
                    end else begin
                        // Overflow: word dropped, count holds at DEPTH.
                        state_d = ERR;
                    end
                end
`ifdef RECEIVE_TIMEOUT_EN
                else begin
                    idle_d = idle_q + TONE_C;
                    if (idle_d == TO_C) state_d = ERR;
                end
`endif
            end
            IDLE, DONE, ERR: begin
                if (r_i_start) begin
                    state_d = RECV;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rd_data_q <= '0;
`ifdef RECEIVE_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
`ifdef RECEIVE_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
            if ({1'b0, r_i_rd_addr} < DEPTH_C) rd_data_q <= mem[r_i_rd_addr];
            else                               rd_data_q <= '0;
        end
    end

    // NOTE: the buffer is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge r_clk) begin
        if (r_rst && wr_en) mem[count_q[AWIDTH-1:0]] <= r_i_instr;
    end

    assign r_o_syn     = (state_q == RECV);
    assign r_o_done    = (state_q == DONE);
    assign r_o_err     = (state_q == ERR);
    assign r_o_count   = count_q;
    assign r_o_rd_data = rd_data_q;

endmodule

// File: tb/tb_receive.sv
// Directed bench for receive (default build: DEPTH=2, IWIDTH=32, watchdog disabled).
module tb_receive;

    logic        r_clk = 1'b0;
    logic        r_rst, r_i_start, r_i_last, r_i_ack, r_o_syn, r_o_done, r_o_err;
    logic [31:0] r_i_instr, r_o_rd_data;
    logic [0:0]  r_i_rd_addr;
    logic [1:0]  r_o_count;
    int          checks = 0;
    int          errors = 0;

    receive #(.IWIDTH(32), .DEPTH(2), .AWIDTH(1), .TIMEOUT(16)) dut (
        .r_clk(r_clk), .r_rst(r_rst), .r_i_start(r_i_start), .r_i_instr(r_i_instr),
        .r_i_last(r_i_last), .r_i_ack(r_i_ack), .r_o_syn(r_o_syn), .r_i_rd_addr(r_i_rd_addr),
        .r_o_rd_data(r_o_rd_data), .r_o_count(r_o_count), .r_o_done(r_o_done), .r_o_err(r_o_err)
    );

    always #5 r_clk = ~r_clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic test_reset();
        r_rst = 1'b0; r_i_start = 1'b0; r_i_ack = 1'b0; r_i_last = 1'b0;
        r_i_instr = '0; r_i_rd_addr = '0;
        tick(); tick();
        checks++; if (r_o_syn !== 1'b0) begin errors++; $display("FAIL rst_syn got %b exp 0", r_o_syn); end
        checks++; if (r_o_count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", r_o_count); end
        checks++; if (r_o_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", r_o_done); end
        checks++; if (r_o_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", r_o_err); end
        checks++; if (r_o_rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd got %h exp 0", r_o_rd_data); end
        r_rst = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        r_i_start = 1'b1; tick(); r_i_start = 1'b0;
        checks++; if (r_o_syn !== 1'b1) begin errors++; $display("FAIL norm_syn_start got %b exp 1", r_o_syn); end
        r_i_ack = 1'b1; r_i_instr = 32'hDEADBEEF; tick();
        checks++; if (r_o_count !== 2'd1 || r_o_syn !== 1'b1) begin errors++; $display("FAIL norm_beat1 got count %0d syn %b exp 1 1", r_o_count, r_o_syn); end
        r_i_instr = 32'h12345678; r_i_last = 1'b1; tick();
        r_i_ack = 1'b0; r_i_last = 1'b0;
        checks++; if (r_o_syn !== 1'b0) begin errors++; $display("FAIL norm_syn_drop got %b exp 0", r_o_syn); end
        checks++; if (r_o_done !== 1'b1 || r_o_count !== 2'd2) begin errors++; $display("FAIL norm_done got done %b count %0d exp 1 2", r_o_done, r_o_count); end
        r_i_rd_addr = 1'b0; tick();
        checks++; if (r_o_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL norm_rd0 got %h exp deadbeef", r_o_rd_data); end
        r_i_rd_addr = 1'b1; tick();
        checks++; if (r_o_rd_data !== 32'h12345678) begin errors++; $display("FAIL norm_rd1 got %h exp 12345678", r_o_rd_data); end
    endtask

    task automatic test_overflow();
        r_i_start = 1'b1; tick(); r_i_start = 1'b0;
        checks++; if (r_o_count !== 2'd0 || r_o_done !== 1'b0) begin errors++; $display("FAIL ovf_restart got count %0d done %b exp 0 0", r_o_count, r_o_done); end
        r_i_ack = 1'b1;
        r_i_instr = 32'hA0A0A0A0; tick();
        r_i_instr = 32'hB1B1B1B1; tick();
        checks++; if (r_o_count !== 2'd2 || r_o_syn !== 1'b1) begin errors++; $display("FAIL ovf_full got count %0d syn %b exp 2 1", r_o_count, r_o_syn); end
        r_i_instr = 32'hC2C2C2C2; tick();
        checks++; if (r_o_err !== 1'b1 || r_o_count !== 2'd2 || r_o_syn !== 1'b0 || r_o_done !== 1'b0) begin
            errors++; $display("FAIL ovf_err got err %b count %0d syn %b done %b exp 1 2 0 0", r_o_err, r_o_count, r_o_syn, r_o_done);
        end
        r_i_instr = 32'hD3D3D3D3; tick();   // ack while in ERR must be discarded
        r_i_ack = 1'b0;
        r_i_rd_addr = 1'b1; tick();
        checks++; if (r_o_rd_data !== 32'hB1B1B1B1) begin errors++; $display("FAIL ovf_rd1 got %h exp b1b1b1b1", r_o_rd_data); end
        r_i_rd_addr = 1'b0; tick();
        checks++; if (r_o_rd_data !== 32'hA0A0A0A0) begin errors++; $display("FAIL ovf_rd0 got %h exp a0a0a0a0", r_o_rd_data); end
    endtask

    task automatic test_gapped();
        r_i_start = 1'b1; tick(); r_i_start = 1'b0;
        checks++; if (r_o_err !== 1'b0 || r_o_syn !== 1'b1) begin errors++; $display("FAIL gap_restart got err %b syn %b exp 0 1", r_o_err, r_o_syn); end
        r_i_ack = 1'b1; r_i_instr = 32'h11110000; tick();
        r_i_ack = 1'b0; r_i_last = 1'b1; r_i_instr = 32'hBAD0BAD0; tick();
        r_i_last = 1'b0; tick();
        checks++; if (r_o_count !== 2'd1 || r_o_done !== 1'b0 || r_o_syn !== 1'b1) begin
            errors++; $display("FAIL gap_hold got count %0d done %b syn %b exp 1 0 1", r_o_count, r_o_done, r_o_syn);
        end
        r_i_ack = 1'b1; r_i_last = 1'b1; r_i_instr = 32'h22221111; tick();
        r_i_ack = 1'b0; r_i_last = 1'b0;
        checks++; if (r_o_count !== 2'd2 || r_o_done !== 1'b1) begin errors++; $display("FAIL gap_done got count %0d done %b exp 2 1", r_o_count, r_o_done); end
        r_i_rd_addr = 1'b0; tick();
        checks++; if (r_o_rd_data !== 32'h11110000) begin errors++; $display("FAIL gap_rd0 got %h exp 11110000", r_o_rd_data); end
        r_i_rd_addr = 1'b1; tick();
        checks++; if (r_o_rd_data !== 32'h22221111) begin errors++; $display("FAIL gap_rd1 got %h exp 22221111", r_o_rd_data); end
    endtask

    task automatic test_restart_from_done();
        r_i_start = 1'b1; r_i_ack = 1'b1; r_i_instr = 32'h99999999; r_i_rd_addr = 1'b0; tick();
        r_i_start = 1'b0; r_i_ack = 1'b0;
        checks++; if (r_o_done !== 1'b0 || r_o_count !== 2'd0 || r_o_syn !== 1'b1) begin
            errors++; $display("FAIL rs_state got done %b count %0d syn %b exp 0 0 1", r_o_done, r_o_count, r_o_syn);
        end
        tick();
        checks++; if (r_o_rd_data !== 32'h11110000) begin errors++; $display("FAIL rs_discard got %h exp 11110000", r_o_rd_data); end
        r_i_ack = 1'b1; r_i_last = 1'b1; r_i_instr = 32'h33334444; tick();
        r_i_ack = 1'b0; r_i_last = 1'b0;
        checks++; if (r_o_done !== 1'b1 || r_o_count !== 2'd1) begin errors++; $display("FAIL rs_done got done %b count %0d exp 1 1", r_o_done, r_o_count); end
        tick();
        checks++; if (r_o_rd_data !== 32'h33334444) begin errors++; $display("FAIL rs_rd0 got %h exp 33334444", r_o_rd_data); end
    endtask

    task automatic test_reset_mid();
        r_i_start = 1'b1; tick(); r_i_start = 1'b0;
        r_i_ack = 1'b1; r_i_instr = 32'h55550000; tick();
        checks++; if (r_o_count !== 2'd1) begin errors++; $display("FAIL mid_beat got count %0d exp 1", r_o_count); end
        r_rst = 1'b0; r_i_instr = 32'h66661111; tick();
        r_rst = 1'b1; r_i_ack = 1'b0;
        checks++; if (r_o_syn !== 1'b0 || r_o_count !== 2'd0 || r_o_done !== 1'b0 || r_o_err !== 1'b0 || r_o_rd_data !== 32'h0) begin
            errors++; $display("FAIL mid_rst got syn %b count %0d done %b err %b rd %h exp 0 0 0 0 0", r_o_syn, r_o_count, r_o_done, r_o_err, r_o_rd_data);
        end
        r_i_rd_addr = 1'b1; tick();
        checks++; if (r_o_rd_data !== 32'h22221111) begin errors++; $display("FAIL mid_nowrite got %h exp 22221111", r_o_rd_data); end
        r_i_rd_addr = 1'b0;
        r_i_start = 1'b1; tick(); r_i_start = 1'b0;
        r_i_ack = 1'b1; r_i_last = 1'b1; r_i_instr = 32'h77772222; tick();
        r_i_ack = 1'b0; r_i_last = 1'b0;
        checks++; if (r_o_count !== 2'd1 || r_o_done !== 1'b1) begin errors++; $display("FAIL mid_fresh got count %0d done %b exp 1 1", r_o_count, r_o_done); end
        tick();
        checks++; if (r_o_rd_data !== 32'h77772222) begin errors++; $display("FAIL mid_rd0 got %h exp 77772222", r_o_rd_data); end
    endtask

    task automatic test_no_timeout();
        r_i_start = 1'b1; tick(); r_i_start = 1'b0;
        repeat (100) tick();
        checks++; if (r_o_syn !== 1'b1 || r_o_err !== 1'b0) begin errors++; $display("FAIL noto_wait got syn %b err %b exp 1 0", r_o_syn, r_o_err); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_overflow();
        test_gapped();
        test_restart_from_done();
        test_reset_mid();
        test_no_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
